sop_operand_feeder: RTL and testbench

- Upstream stage of the 4-term sum-of-products datapath (TopLevel).
- Turns a serial sample stream (valid/ready) into the four parallel data operands d1..d4 through a 4-tap delay line.
- Holds the four coefficients c1..c4 loaded through a small write port.
- Emits an operand-valid strobe, plus a result-valid strobe delayed to line up with TopLevel's final_out.

---
 rtl/sop_pkg.sv | 18 +
 rtl/sop_valid_delay.sv | 30 +++
 rtl/sop_operand_feeder.sv | 118 +++++++++++
 tb/tb_sop_operand_feeder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared constants and types for the sum-of-products datapath: state encoding,
// default operand width, tap count and the downstream result width helper.
package sop_pkg;

  localparam int SOP_WIDTH = 4;
  localparam int TAPS      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic int sop_out_w(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/sop_valid_delay.sv
// Fixed-latency shift register that carries the operand-valid tag forward so it
// lines up with the downstream sum-of-products result.
module sop_valid_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[LAT-1];

endmodule

// File: rtl/sop_operand_feeder.sv
// Upstream operand stage: serial samples into a 4-tap delay line, coefficient
// register file, and valid strobes aligned to the sum-of-products result.
module sop_operand_feeder
  import sop_pkg::*;
#(
  parameter int WIDTH   = SOP_WIDTH,
  parameter int SOP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             flush,
  input  logic             coef_we,
  input  logic [1:0]       coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] c2,
  output logic [WIDTH-1:0] c3,
  output logic [WIDTH-1:0] c4,
  output logic             op_valid,
  output logic             res_valid,
  output logic             coef_err,
  output logic [1:0]       state_o
);

  state_t           state, state_nxt;
  logic [2:0]       fill_cnt, fill_inc;
  logic             active, accept, full_now, tag_clr;
  logic [WIDTH-1:0] dl   [TAPS];
  logic [WIDTH-1:0] coef [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // stop outranks flush; flush restarts the fill from wherever we are.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_FILL;
      ST_FILL, ST_RUN: begin
        if (stop)                           state_nxt = ST_IDLE;
        else if (flush)                     state_nxt = ST_FILL;
        else if (state == ST_FILL && full_now) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    active   = (state != ST_IDLE);
    s_ready  = active && !flush && !stop;
    accept   = s_valid && s_ready;
    fill_inc = (fill_cnt >= 3'(TAPS)) ? 3'(TAPS) : fill_cnt + 3'd1;
    full_now = accept && (fill_inc == 3'(TAPS));
    tag_clr  = active && flush && !stop;
    state_o  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
      fill_cnt <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= full_now;
      if (!active) begin
        if (start) fill_cnt <= '0;
      end else if (flush) begin
        for (int i = 0; i < TAPS; i++) dl[i] <= '0;
        fill_cnt <= '0;
      end else if (accept) begin
        dl[0] <= s_data;
        for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
        fill_cnt <= fill_inc;
      end
    end
  end

  // Coefficients are only writable while idle so a running window never
  // mixes old and new weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      coef_err <= 1'b0;
    end else if (coef_we) begin
      if (!active) coef[coef_addr] <= coef_data;
      else         coef_err <= 1'b1;
    end
  end

  sop_valid_delay #(.LAT(SOP_LAT)) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tag_clr),
    .din   (op_valid),
    .dout  (res_valid)
  );

  assign d1 = dl[0];
  assign d2 = dl[1];
  assign d3 = dl[2];
  assign d4 = dl[3];
  assign c1 = coef[0];
  assign c2 = coef[1];
  assign c3 = coef[2];
  assign c4 = coef[3];

endmodule

// File: tb/tb_sop_operand_feeder.sv
// Directed bench: a SOP_LAT=1 instance checked in full, plus a SOP_LAT=3
// instance on the same inputs whose res_valid timing is checked.
module tb_sop_operand_feeder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, flush, coef_we, s_valid;
  logic [1:0]   coef_addr;
  logic [W-1:0] coef_data, s_data;
  logic         s_ready, op_valid, res_valid, coef_err;
  logic [W-1:0] d1, d2, d3, d4, c1, c2, c3, c4;
  logic [1:0]   state_o;

  logic         x_s_ready, x_op_valid, res_valid3, x_coef_err;
  logic [W-1:0] x_d1, x_d2, x_d3, x_d4, x_c1, x_c2, x_c3, x_c4;
  logic [1:0]   x_state_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sop_operand_feeder #(.WIDTH(W), .SOP_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .op_valid(op_valid), .res_valid(res_valid), .coef_err(coef_err),
    .state_o(state_o)
  );

  sop_operand_feeder #(.WIDTH(W), .SOP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(x_s_ready), .s_data(s_data),
    .d1(x_d1), .d2(x_d2), .d3(x_d3), .d4(x_d4),
    .c1(x_c1), .c2(x_c2), .c3(x_c3), .c4(x_c4),
    .op_valid(x_op_valid), .res_valid(res_valid3), .coef_err(x_coef_err),
    .state_o(x_state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [W-1:0] sd);
    s_valid = sv;
    s_data  = sd;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkWindow(input string tag, input logic [W-1:0] e1, input logic [W-1:0] e2,
                             input logic [W-1:0] e3, input logic [W-1:0] e4);
    checkOutput({tag, "_d1"}, 32'(d1), 32'(e1));
    checkOutput({tag, "_d2"}, 32'(d2), 32'(e2));
    checkOutput({tag, "_d3"}, 32'(d3), 32'(e3));
    checkOutput({tag, "_d4"}, 32'(d4), 32'(e4));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // short run, then an asynchronous reset between clock edges
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("pre_reset_state", 32'(state_o), 32'd1);
    applyStimulus(1'b1, 4'd5);
    checkOutput("pre_reset_d1", 32'(d1), 32'd5);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_d1", 32'(d1), 32'd0);
    checkOutput("rst_op_valid", 32'(op_valid), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_coef_err", 32'(coef_err), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // coefficient load; last write coincides with start
    coef_we = 1'b1;
    coef_addr = 2'd0; coef_data = 4'd1; tick();
    coef_addr = 2'd1; coef_data = 4'd2; tick();
    coef_addr = 2'd2; coef_data = 4'd3; tick();
    coef_addr = 2'd3; coef_data = 4'd3; start = 1'b1; tick();
    coef_we = 1'b0; start = 1'b0;
    checkOutput("c1", 32'(c1), 32'd1);
    checkOutput("c2", 32'(c2), 32'd2);
    checkOutput("c3", 32'(c3), 32'd3);
    checkOutput("c4", 32'(c4), 32'd3);
    checkOutput("start_state", 32'(state_o), 32'd1);
    checkOutput("fill_s_ready", 32'(s_ready), 32'd1);

    // fill with 1,2,3,2
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd3);
    checkOutput("fill3_op_valid", 32'(op_valid), 32'd0);
    checkOutput("fill3_state", 32'(state_o), 32'd1);
    applyStimulus(1'b1, 4'd2);
    checkOutput("fill4_op_valid", 32'(op_valid), 32'd1);
    checkOutput("fill4_res_valid", 32'(res_valid), 32'd0);
    checkOutput("fill4_state", 32'(state_o), 32'd2);
    checkWindow("fill4", 4'd2, 4'd3, 4'd2, 4'd1);
    applyStimulus(1'b0, 4'd0);
    checkOutput("t1_op_valid", 32'(op_valid), 32'd0);
    checkOutput("t1_res_valid", 32'(res_valid), 32'd1);

    // backpressure pattern 1,0,1 in RUN
    applyStimulus(1'b1, 4'd4);
    checkOutput("t2_op_valid", 32'(op_valid), 32'd1);
    checkOutput("t2_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t2_res_valid3", 32'(res_valid3), 32'd0);
    applyStimulus(1'b0, 4'd0);
    checkOutput("t3_op_valid", 32'(op_valid), 32'd0);
    checkOutput("t3_res_valid", 32'(res_valid), 32'd1);
    checkOutput("t3_res_valid3", 32'(res_valid3), 32'd1);
    applyStimulus(1'b1, 4'd5);
    checkOutput("t4_op_valid", 32'(op_valid), 32'd1);
    checkOutput("t4_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t4_res_valid3", 32'(res_valid3), 32'd0);
    checkWindow("t4", 4'd5, 4'd4, 4'd2, 4'd3);

    // flush with a sample offered: rejected, window cleared, tags squashed
    flush = 1'b1; s_valid = 1'b1; s_data = 4'd7;
    #1;
    checkOutput("flush_s_ready", 32'(s_ready), 32'd0);
    tick();
    flush = 1'b0;
    checkWindow("flush", 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("flush_state", 32'(state_o), 32'd1);
    checkOutput("flush_op_valid", 32'(op_valid), 32'd0);
    checkOutput("flush_res_valid", 32'(res_valid), 32'd0);
    checkOutput("flush_res_valid3", 32'(res_valid3), 32'd0);
    checkOutput("flush_c3_kept", 32'(c3), 32'd3);

    // refill needs four fresh samples
    applyStimulus(1'b1, 4'd8);
    applyStimulus(1'b1, 4'd8);
    applyStimulus(1'b1, 4'd8);
    checkOutput("refill3_op_valid", 32'(op_valid), 32'd0);
    applyStimulus(1'b1, 4'd9);
    checkOutput("refill4_op_valid", 32'(op_valid), 32'd1);
    checkOutput("refill4_state", 32'(state_o), 32'd2);
    checkWindow("refill4", 4'd9, 4'd8, 4'd8, 4'd8);
    s_valid = 1'b0;

    // illegal coefficient write in RUN
    coef_we = 1'b1; coef_addr = 2'd2; coef_data = 4'd5;
    tick();
    coef_we = 1'b0;
    checkOutput("illegal_c3", 32'(c3), 32'd3);
    checkOutput("illegal_coef_err", 32'(coef_err), 32'd1);

    // stop together with flush
    stop = 1'b1; flush = 1'b1; s_valid = 1'b1; s_data = 4'd6;
    #1;
    checkOutput("stop_s_ready", 32'(s_ready), 32'd0);
    tick();
    stop = 1'b0; flush = 1'b0; s_valid = 1'b0;
    checkOutput("stop_state", 32'(state_o), 32'd0);
    checkWindow("stop", 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("stop_op_valid", 32'(op_valid), 32'd0);
    tick();
    checkOutput("sticky_coef_err", 32'(coef_err), 32'd1);
    checkOutput("idle_s_ready", 32'(s_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
